mfe_param: RTL and testbench
============================

Name: mfe_param

Overview:
- Parametrised successor to the fixed 128x128 median filter engine.
- Reads a greyscale image of IMG_W x IMG_H pixels through the iaddr/idata image port, applies a 3x3 window filter in raster order, and writes one result per pixel to the result memory through addr/data_wr/wen.
- Adds a runtime mode select (median/max/min/pass) and a sliding column window: only one new column is fetched per output pixel.

Parameters:
- IMG_W, 128: image width in pixels, >= 3.
- IMG_H, 128: image height in pixels, >= 3.
- DW, 8: pixel width in bits, unsigned.
- AW, 14: address width; must satisfy 2^AW >= IMG_W*IMG_H.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready  in  1  start request; sampled only in IDLE.
- mode  in  2  0 = median, 1 = max, 2 = min, 3 = pass (centre pixel); latched at start.
- busy  out  1  high from start until the last write completes.
- iaddr  out  AW  image read address, row-major y*IMG_W+x; registered.
- idata  in  DW  image pixel for the current iaddr; valid before the next rising edge, sampled there.
- addr  out  AW  result write address, row-major.
- data_wr  out  DW  result pixel.
- wen  out  1  1 = write data_wr to addr this cycle.

Behaviour:
- Reset values: all outputs 0, i.e. busy=0, wen=0, iaddr=0, addr=0, data_wr=0.
  - State goes to IDLE and the window clears to 0.
  - Reset asserted mid-run abandons the run immediately; no further writes.
- IDLE: busy=0, wen=0.
  - ready=1 at a rising edge latches mode and sets y=0, x=0.
  - Same edge: busy<=1 and state<=FETCH.
- Window: three columns of three pixels (L, C, R).
  - A column fetch shifts L<=C, C<=R, R<=new column.
- Row start:
  - Window cleared to 0, then column 0 and column 1 fetched (6 cycles).
  - Result: L=pad, C=col0, R=col1.
- FETCH: 3 cycles per column, rows y-1, y, y+1 in that order, one iaddr per cycle.
  - Out-of-image coordinates (row -1, row IMG_H, column IMG_W) are not read.
  - In those cycles iaddr holds its previous value, idata is ignored, and 0 is shifted in.
  - After the last column cycle go to CALC.
- CALC (1 cycle): registers the filter result of the 9 window values.
  - Median = 5th smallest, unsigned; ties counted by multiplicity.
  - max and min are unsigned.
  - pass returns the window centre.
- WRITE (1 cycle): wen=1, addr=y*IMG_W+x, data_wr=registered result.
  - If x<IMG_W-1: x++ and FETCH column x+2 (padding if x+2==IMG_W).
  - Else if y<IMG_H-1: y++, x=0, row start.
  - Else: state<=IDLE and busy<=0 at the next edge.
- wen is 0 in every state except WRITE. Exactly IMG_W*IMG_H writes per run, each address written once, in ascending order.
- Latency:
  - Busy high for exactly IMG_H*(5*IMG_W+3) cycles; 82304 at the defaults.
  - First write occurs in cycle 8 of busy.
- ready while busy: ignored.
- ready held high through the end of a run: a new run starts on the first IDLE edge.
- mode changes during a run: no effect.
- Unsigned compare only; no arithmetic overflow possible; result width DW.

Optional Feature:
- Macro MFE_BORDER_REPLICATE_EN.
- Defined: out-of-image coordinates are clamped to the nearest valid row/column.
  - Those cycles perform a real read at the clamped iaddr and shift in that idata.
  - Row start window is then L=col0, C=col0, R=col1.
- Undefined: zero padding as described under Behaviour.
- Cycle counts are identical in both builds.

Test Plan:
- IMG_W=IMG_H=4, all pixels 50, mode 0 -> corners 0, non-corner edges 50, interior 50; busy high exactly 92 cycles; 16 writes at addr 0..15.
- Same image, mode 1 -> all 50. Mode 2 -> all 12 border pixels 0, the 4 interior pixels 50. With MFE_BORDER_REPLICATE_EN, modes 0/1/2 -> all 50.
- 4x4 zeros with 255 at (1,1): mode 0 -> all 0; mode 1 -> addr 0,1,2,4,5,6,8,9,10 = 255, others 0; mode 3 -> only addr 5 = 255.
- 4x4 ramp, pixel value = index 0..15, mode 0 -> addr 5 = 5, addr 10 = 10; mode 3 -> output equals input.
- reset pulsed at busy cycle 40 -> busy=0 and wen=0 immediately; then a ready pulse -> full 92-cycle run with correct output.
- ready held high for 200 cycles -> second run starts the edge after busy falls; ready pulses during busy -> no effect on count or outputs.

Source files
------------

// File: rtl/mfe_param.sv
// mfe_param: parametrised 3x3 window filter engine (median / max / min / pass).
// Reads an IMG_W x IMG_H image in raster order through iaddr/idata and writes
// one filtered pixel per location through addr/data_wr/wen. The window slides
// by one column per output pixel, so each pixel costs 3 fetch + calc + write.
// Optional build macro: MFE_BORDER_REPLICATE_EN clamps out-of-image reads to
// the nearest valid row/column instead of zero padding.
module mfe_param #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  output logic          wen
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CALC, S_WRITE} state_t;

  state_t state, state_nx;

  logic [AW-1:0] x, y, row_base, fcol;
  logic [1:0]    phase;
  logic          first;
  logic          fvalid;
  logic [1:0]    mode_q;
  logic [DW-1:0] win [9];
  logic [DW-1:0] t0, t1, pix;

  logic          nf_go;
  logic [1:0]    nf_phase;
  logic [AW-1:0] nf_col, nf_y, nf_base;
  logic          row_lo, row_hi, col_hi;
  logic [AW-1:0] row_addr, nf_addr;
  logic          nf_valid;

  logic [3:0]    lt, le;
  logic [DW-1:0] med, mx, mn, filt;

  // Window index = column*3 + row (L: 0..2, C: 3..5, R: 6..8); centre is 4.
  assign pix = fvalid ? idata : '0;
  assign wen = (state == S_WRITE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state, and the fetch position for the following cycle so that
  // iaddr can be registered one cycle ahead of the idata sample.
  always_comb begin
    state_nx = state;
    nf_go    = 1'b0;
    nf_phase = phase;
    nf_col   = fcol;
    nf_y     = y;
    nf_base  = row_base;
    case (state)
      S_IDLE: begin
        if (ready) begin
          state_nx = S_FETCH;
          nf_go    = 1'b1;
          nf_phase = 2'd0;
          nf_col   = '0;
          nf_y     = '0;
          nf_base  = '0;
        end
      end
      S_FETCH: begin
        if (phase != 2'd2) begin
          nf_go    = 1'b1;
          nf_phase = phase + 2'd1;
        end else if (first) begin
          nf_go    = 1'b1;
          nf_phase = 2'd0;
          nf_col   = fcol + AW'(1);
        end else begin
          state_nx = S_CALC;
        end
      end
      S_CALC: state_nx = S_WRITE;
      S_WRITE: begin
        if (x < AW'(IMG_W - 1)) begin
          state_nx = S_FETCH;
          nf_go    = 1'b1;
          nf_phase = 2'd0;
          nf_col   = x + AW'(2);
        end else if (y < AW'(IMG_H - 1)) begin
          state_nx = S_FETCH;
          nf_go    = 1'b1;
          nf_phase = 2'd0;
          nf_col   = '0;
          nf_y     = y + AW'(1);
          nf_base  = row_base + AW'(IMG_W);
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Address of the next fetch; out-of-image rows/columns are either skipped
  // (zero padding) or clamped onto the border.
  always_comb begin
    row_lo   = (nf_phase == 2'd0) && (nf_y == '0);
    row_hi   = (nf_phase == 2'd2) && (nf_y == AW'(IMG_H - 1));
    col_hi   = (nf_col == AW'(IMG_W));
    row_addr = nf_base;
    if (nf_phase == 2'd0 && !row_lo) row_addr = nf_base - AW'(IMG_W);
    if (nf_phase == 2'd2 && !row_hi) row_addr = nf_base + AW'(IMG_W);
    nf_addr  = row_addr + (col_hi ? AW'(IMG_W - 1) : nf_col);
`ifdef MFE_BORDER_REPLICATE_EN
    nf_valid = 1'b1;
`else
    nf_valid = !(row_lo || row_hi || col_hi);
`endif
  end

  // Filter of the 9 window values; median is the element with at most 4
  // strictly smaller and at least 5 smaller-or-equal values.
  always_comb begin
    med = '0;
    mx  = '0;
    mn  = '1;
    lt  = '0;
    le  = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      lt = '0;
      le = '0;
      for (int unsigned j = 0; j < 9; j++) begin
        if (win[j] <  win[i]) lt = lt + 4'd1;
        if (win[j] <= win[i]) le = le + 4'd1;
      end
      if (lt <= 4'd4 && le >= 4'd5) med = win[i];
      if (win[i] > mx) mx = win[i];
      if (win[i] < mn) mn = win[i];
    end
    case (mode_q)
      2'd0:    filt = med;
      2'd1:    filt = mx;
      2'd2:    filt = mn;
      default: filt = win[4];
    endcase
  end

  // Datapath: fetch address, column assembly, window shift, result and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      iaddr    <= '0;
      addr     <= '0;
      data_wr  <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      fcol     <= '0;
      phase    <= '0;
      first    <= 1'b0;
      fvalid   <= 1'b0;
      mode_q   <= '0;
      t0       <= '0;
      t1       <= '0;
      for (int unsigned i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      if (nf_go) begin
        phase  <= nf_phase;
        fcol   <= nf_col;
        fvalid <= nf_valid;
        if (nf_valid) iaddr <= nf_addr;
      end
      case (state)
        S_IDLE: begin
          if (ready) begin
            busy     <= 1'b1;
            mode_q   <= mode;
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            first    <= 1'b1;
            for (int unsigned i = 0; i < 9; i++) win[i] <= '0;
          end
        end
        S_FETCH: begin
          case (phase)
            2'd0: t0 <= pix;
            2'd1: t1 <= pix;
            default: begin
              first <= 1'b0;
`ifdef MFE_BORDER_REPLICATE_EN
              // Row start: column 0 also stands in for the missing left column.
              if (first) begin
                win[0] <= t0; win[1] <= t1; win[2] <= pix;
                win[3] <= t0; win[4] <= t1; win[5] <= pix;
              end else begin
                win[0] <= win[3]; win[1] <= win[4]; win[2] <= win[5];
                win[3] <= win[6]; win[4] <= win[7]; win[5] <= win[8];
              end
`else
              win[0] <= win[3]; win[1] <= win[4]; win[2] <= win[5];
              win[3] <= win[6]; win[4] <= win[7]; win[5] <= win[8];
`endif
              win[6] <= t0; win[7] <= t1; win[8] <= pix;
            end
          endcase
        end
        S_CALC: begin
          data_wr <= filt;
          addr    <= row_base + x;
        end
        S_WRITE: begin
          if (x < AW'(IMG_W - 1)) begin
            x <= x + AW'(1);
          end else if (y < AW'(IMG_H - 1)) begin
            x        <= '0;
            y        <= y + AW'(1);
            row_base <= row_base + AW'(IMG_W);
            first    <= 1'b1;
            for (int unsigned i = 0; i < 9; i++) win[i] <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mfe_param.sv
// tb_mfe_param: directed and randomised runs of a 4x4 mfe_param, with output
// pixels compared against a neighbourhood-sort reference model.
module tb_mfe_param;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, ready;
  logic [1:0]    mode;
  logic          busy, wen;
  logic [AW-1:0] iaddr, addr;
  logic [DW-1:0] idata, data_wr;

  logic [7:0]    img [16];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int busy_cyc, first_wr;
  logic [1:0]    exp_mode;
  logic [AW-1:0] wa [$];
  logic [7:0]    wd [$];

  always #5 clk = ~clk;

  assign idata = img[iaddr];

  mfe_param #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .mode(mode), .busy(busy),
    .iaddr(iaddr), .idata(idata), .addr(addr), .data_wr(data_wr), .wen(wen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_pix(input int y, input int x, input logic [1:0] m);
    int q [$];
    int yy, xx, v;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        yy = y + dy;
        xx = x + dx;
`ifdef MFE_BORDER_REPLICATE_EN
        if (yy < 0) yy = 0;
        if (yy > H - 1) yy = H - 1;
        if (xx < 0) xx = 0;
        if (xx > W - 1) xx = W - 1;
        v = int'(img[yy * W + xx]);
`else
        if (yy < 0 || yy >= H || xx < 0 || xx >= W) v = 0;
        else v = int'(img[yy * W + xx]);
`endif
        q.push_back(v);
      end
    end
    q.sort();
    case (m)
      2'd0:    return 8'(q[4]);
      2'd1:    return 8'(q[8]);
      2'd2:    return 8'(q[0]);
      default: return img[y * W + x];
    endcase
  endfunction

  task automatic start(input logic [1:0] m);
    mode     = m;
    exp_mode = m;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  // Called in busy cycle 1; returns at the first negedge with busy low.
  task automatic collect(input bit jitter);
    busy_cyc = 0;
    first_wr = 0;
    wa.delete();
    wd.delete();
    for (int c = 0; c < 2000 && busy === 1'b1; c++) begin
      busy_cyc++;
      if (wen === 1'b1) begin
        wa.push_back(addr);
        wd.push_back(data_wr);
        if (first_wr == 0) first_wr = busy_cyc;
      end
      if (jitter) begin
        ready = 1'($urandom);
        mode  = 2'($urandom);
      end
      @(negedge clk);
    end
    if (jitter) ready = 1'b0;
    chk("busy_end", busy, 0);
    chk("wen_idle", wen, 0);
  endtask

  task automatic verify(input string name);
    chk($sformatf("%s_busy_cycles", name), busy_cyc, H * (5 * W + 3));
    chk($sformatf("%s_nwrites", name), wa.size(), W * H);
    chk($sformatf("%s_first_wr", name), first_wr, 8);
    for (int i = 0; i < wa.size() && i < W * H; i++) begin
      chk($sformatf("%s_addr%0d", name, i), wa[i], i);
      chk($sformatf("%s_data%0d", name, i), wd[i], ref_pix(i / W, i % W, exp_mode));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    mode  = 2'd0;
    exp_mode = 2'd0;
    for (int i = 0; i < 16; i++) img[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wen", wen, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data_wr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Uniform 50 image.
    for (int i = 0; i < 16; i++) img[i] = 8'd50;
    start(2'd0); collect(0); verify("flat_med");
`ifdef MFE_BORDER_REPLICATE_EN
    chk("flat_med_corner", wd[0], 50);
`else
    chk("flat_med_corner", wd[0], 0);
`endif
    chk("flat_med_edge", wd[1], 50);
    start(2'd1); collect(0); verify("flat_max");
    start(2'd2); collect(0); verify("flat_min");
    chk("flat_min_inner", wd[5], 50);

    // Single bright pixel at (1,1).
    for (int i = 0; i < 16; i++) img[i] = 8'd0;
    img[5] = 8'd255;
    start(2'd0); collect(0); verify("imp_med");
    start(2'd1); collect(0); verify("imp_max");
    chk("imp_max_a0", wd[0], 255);
    chk("imp_max_a3", wd[3], 0);
    start(2'd3); collect(0); verify("imp_pass");

    // Ramp image.
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    start(2'd0); collect(0); verify("ramp_med");
    chk("ramp_med_a5", wd[5], 5);
    chk("ramp_med_a10", wd[10], 10);
    start(2'd3); collect(0); verify("ramp_pass");

    // Reset in busy cycle 40, then a clean run.
    start(2'd0);
    for (int c = 1; c < 40; c++) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wen", wen, 0);
    @(negedge clk);
    chk("abort_hold_wen", wen, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    start(2'd2); collect(0); verify("after_abort");

    // ready held high across two runs.
    fill_random();
    mode = 2'd1; exp_mode = 2'd1;
    ready = 1'b1;
    @(negedge clk);
    collect(0); verify("held1");
    mode = 2'd2; exp_mode = 2'd2;
    @(negedge clk);
    chk("held_restart", busy, 1);
    collect(0);
    ready = 1'b0;
    verify("held2");
    @(negedge clk);
    chk("held_stop", busy, 0);

    // ready and mode toggled during the run.
    for (int r = 0; r < 6; r++) begin
      fill_random();
      start(2'($urandom));
      collect(r % 2 == 0);
      verify($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
